// File: rtl/qtcore_a1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qtcore_a1_pkg
// Purpose  : State codes, opcode nibbles and F-group subcodes for QTCore-A1
// Revision : 1.0 - initial release
// ============================================================================
package qtcore_a1_pkg;

    localparam int CHAIN_LEN = 168;

    localparam logic [2:0] c_st_fetch = 3'b001;
    localparam logic [2:0] c_st_exec  = 3'b010;
    localparam logic [2:0] c_st_halt  = 3'b100;

    localparam logic [3:0] c_op_lda  = 4'h0;
    localparam logic [3:0] c_op_add  = 4'h1;
    localparam logic [3:0] c_op_sta  = 4'h2;
    localparam logic [3:0] c_op_sub  = 4'h3;
    localparam logic [3:0] c_op_and  = 4'h4;
    localparam logic [3:0] c_op_or   = 4'h5;
    localparam logic [3:0] c_op_xor  = 4'h6;
    localparam logic [3:0] c_op_jmp  = 4'h8;
    localparam logic [3:0] c_op_bz   = 4'h9;
    localparam logic [3:0] c_op_bnz  = 4'hA;
    localparam logic [3:0] c_op_lui  = 4'hB;
    localparam logic [3:0] c_op_subi = 4'hD;
    localparam logic [3:0] c_op_addi = 4'hE;
    localparam logic [3:0] c_op_fgrp = 4'hF;

    localparam logic [3:0] c_f_inc = 4'h1;
    localparam logic [3:0] c_f_clr = 4'h2;
    localparam logic [3:0] c_f_dec = 4'h3;
    localparam logic [3:0] c_f_not = 4'h4;
    localparam logic [3:0] c_f_shl = 4'h5;
    localparam logic [3:0] c_f_shr = 4'h6;
    localparam logic [3:0] c_f_rol = 4'h7;
    localparam logic [3:0] c_f_neg = 4'h8;
    localparam logic [3:0] c_f_ror = 4'h9;
    localparam logic [3:0] c_f_hlt = 4'hF;

endpackage
`default_nettype wire

// File: rtl/qtcore_a1_alu.sv
`default_nettype none
// ============================================================================
// Module   : qtcore_a1_alu
// Purpose  : Combinational accumulator ALU; the lock skews the shared adder
// Revision : 1.0 - initial release
// ============================================================================
module qtcore_a1_alu
    import qtcore_a1_pkg::*;
(
    input  logic [7:0] i_op,
    input  logic [7:0] i_acc,
    input  logic [7:0] i_operand,
    input  logic       i_locked,
    output logic [7:0] o_result
);

    logic [7:0] w_add_b;
    logic [7:0] w_sum;

    // ADD, ADDI and INC share one adder whose carry-in is the lock state
    always_comb begin
        w_add_b = i_operand;
        if (i_op[7:4] == c_op_addi) begin
            w_add_b = {4'h0, i_op[3:0]};
        end else if (i_op[7:4] == c_op_fgrp) begin
            w_add_b = 8'h01;
        end
    end

    assign w_sum = i_acc + w_add_b + {7'h00, i_locked};

    always_comb begin
        o_result = i_acc;
        case (i_op[7:4])
            c_op_lda:  o_result = i_operand;
            c_op_add:  o_result = w_sum;
            c_op_sub:  o_result = i_acc - i_operand;
            c_op_and:  o_result = i_acc & i_operand;
            c_op_or:   o_result = i_acc | i_operand;
            c_op_xor:  o_result = i_acc ^ i_operand;
            c_op_lui:  o_result = {i_op[3:0], 4'h0};
            c_op_subi: o_result = i_acc - {4'h0, i_op[3:0]};
            c_op_addi: o_result = w_sum;
            c_op_fgrp: begin
                case (i_op[3:0])
                    c_f_inc: o_result = w_sum;
                    c_f_clr: o_result = 8'h00;
                    c_f_dec: o_result = i_acc - 8'h01;
                    c_f_not: o_result = ~i_acc;
                    c_f_shl: o_result = {i_acc[6:0], 1'b0};
                    c_f_shr: o_result = {1'b0, i_acc[7:1]};
                    c_f_rol: o_result = {i_acc[6:0], i_acc[7]};
                    c_f_neg: o_result = 8'h00 - i_acc;
                    c_f_ror: o_result = {i_acc[0], i_acc[7:1]};
                    default: o_result = i_acc;
                endcase
            end
            default:   o_result = i_acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/qtcore_a1_locked_top.sv
`default_nettype none
// ============================================================================
// Module   : qtcore_a1_locked_top
// Purpose  : Logic-locked QTCore-A1 accumulator CPU with a 168-bit scan chain
// Revision : 1.0 - initial release
// ============================================================================
module qtcore_a1_locked_top
    import qtcore_a1_pkg::*;
#(
    parameter logic [15:0] LOCK_KEY = 16'hA5C3
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic                 w_clk;
    logic                 w_rst_n;
    logic                 w_scan_en_n;
    logic                 w_proc_en_n;
    logic                 w_scan_in;
    logic                 w_unused_io;

    logic [CHAIN_LEN-1:0] r_chain;
    logic [CHAIN_LEN-1:0] w_run_nxt;

    logic [2:0]           w_state;
    logic [4:0]           w_pc;
    logic [7:0]           w_ir;
    logic [7:0]           w_acc;
    logic [15:0]          w_key;
    logic [7:0]           w_mem [16];

    logic [2:0]           w_state_nxt;
    logic [4:0]           w_pc_nxt;
    logic [7:0]           w_ir_nxt;
    logic [7:0]           w_acc_nxt;
    logic                 w_mem_we;
    logic [7:0]           w_mem_lsb;
    logic [7:0]           w_alu_result;
    logic                 w_locked;

    assign w_clk       = io_in[0];
    assign w_rst_n     = io_in[1];
    assign w_scan_en_n = io_in[2];
    assign w_proc_en_n = io_in[3];
    assign w_scan_in   = io_in[4];
    assign w_unused_io = ^io_in[7:5];

    // Chain layout, LSB first: STATE, PC, IR, ACC, MEM0..MEM15, KEY
    assign w_state = r_chain[2:0];
    assign w_pc    = r_chain[7:3];
    assign w_ir    = r_chain[15:8];
    assign w_acc   = r_chain[23:16];
    assign w_key   = r_chain[167:152];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mem
            assign w_mem[gi] = r_chain[24 + 8*gi +: 8];
        end
    endgenerate

    assign w_locked  = (w_key != LOCK_KEY);
    assign w_mem_lsb = {1'b0, w_ir[3:0], 3'b000} + 8'd24;

    qtcore_a1_alu u_alu (
        .i_op      (w_ir),
        .i_acc     (w_acc),
        .i_operand (w_mem[w_ir[3:0]]),
        .i_locked  (w_locked),
        .o_result  (w_alu_result)
    );

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            r_chain <= {{(CHAIN_LEN-3){1'b0}}, c_st_fetch};
        end else if (!w_scan_en_n) begin
            r_chain <= {r_chain[CHAIN_LEN-2:0], w_scan_in};
        end else if (!w_proc_en_n) begin
            r_chain <= w_run_nxt;
        end
    end

    always_comb begin
        w_state_nxt = c_st_fetch;
        case (w_state)
            c_st_fetch: w_state_nxt = c_st_exec;
            c_st_exec:  w_state_nxt = (w_ir == {c_op_fgrp, c_f_hlt}) ? c_st_halt : c_st_fetch;
            c_st_halt:  w_state_nxt = c_st_halt;
            default:    w_state_nxt = c_st_fetch;
        endcase
    end

    always_comb begin
        w_pc_nxt  = w_pc;
        w_ir_nxt  = w_ir;
        w_acc_nxt = w_acc;
        w_mem_we  = 1'b0;
        if (w_state == c_st_fetch) begin
            w_ir_nxt = w_mem[w_pc[3:0]];
            w_pc_nxt = w_pc + 5'd1;
        end else if (w_state == c_st_exec) begin
            w_acc_nxt = w_alu_result;
            case (w_ir[7:4])
                c_op_sta: w_mem_we = 1'b1;
                c_op_jmp: w_pc_nxt = {1'b0, w_ir[3:0]};
                c_op_bz:  if (w_acc == 8'h00) w_pc_nxt = {1'b0, w_ir[3:0]};
                c_op_bnz: if (w_acc != 8'h00) w_pc_nxt = {1'b0, w_ir[3:0]};
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_run_nxt         = r_chain;
        w_run_nxt[2:0]    = w_state_nxt;
        w_run_nxt[7:3]    = w_pc_nxt;
        w_run_nxt[15:8]   = w_ir_nxt;
        w_run_nxt[23:16]  = w_acc_nxt;
        if (w_mem_we) begin
            w_run_nxt[w_mem_lsb +: 8] = w_acc;
        end
    end

    assign io_out[6:0] = w_mem[15][6:0];
    assign io_out[7]   = w_scan_en_n ? (w_state == c_st_halt) : r_chain[CHAIN_LEN-1];

endmodule
`default_nettype wire

// File: tb/tb_qtcore_a1_locked_top.sv
`default_nettype none
// Testbench for qtcore_a1_locked_top: scan-load images, run, scan-out and compare.
module tb_qtcore_a1_locked_top;

    localparam logic [15:0] KEY_OK  = 16'hA5C3;
    localparam logic [15:0] KEY_BAD = 16'hA5C2;

    typedef struct {
        string       name;
        logic [7:0]  instr;
        logic [7:0]  acc;
        logic [15:0] key;
        logic [2:0]  st;
        int          ncyc;
        logic [4:0]  exp_pc;
        logic [7:0]  exp_acc;
        logic [7:0]  exp_ir;
        logic [2:0]  exp_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, scan_en_n, proc_en_n, scan_in;
    wire  [7:0] io_in;
    logic [7:0] io_out;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    assign io_in = {3'b000, scan_in, proc_en_n, scan_en_n, rst_n, clk};

    qtcore_a1_locked_top #(.LOCK_KEY(KEY_OK)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_img(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [167:0] mk(input logic [15:0] key, input logic [127:0] mem,
                                        input logic [7:0] acc, input logic [7:0] ir,
                                        input logic [4:0] pc, input logic [2:0] st);
        return {key, mem, acc, ir, pc, st};
    endfunction

    task automatic scan(input logic [167:0] din, output logic [167:0] dout);
        for (int i = 0; i < 168; i++) begin
            @(negedge clk);
            scan_en_n = 1'b0;
            scan_in   = din[167-i];
            #1;
            dout[167-i] = io_out[7];
        end
        @(negedge clk);
        scan_en_n = 1'b1;
        scan_in   = 1'b0;
    endtask

    task automatic load(input logic [167:0] din);
        logic [167:0] dummy;
        scan(din, dummy);
    endtask

    task automatic readout(output logic [167:0] dout);
        scan('0, dout);
    endtask

    task automatic run(input int n);
        @(negedge clk);
        proc_en_n = 1'b0;
        repeat (n) @(negedge clk);
        proc_en_n = 1'b1;
    endtask

    task automatic add_vec(input string name, input logic [7:0] instr, input logic [7:0] acc,
                           input logic [15:0] key, input logic [2:0] st, input int ncyc,
                           input logic [4:0] epc, input logic [7:0] eacc,
                           input logic [7:0] eir, input logic [2:0] est);
        vec_t v;
        v.name = name; v.instr = instr; v.acc = acc; v.key = key; v.st = st; v.ncyc = ncyc;
        v.exp_pc = epc; v.exp_acc = eacc; v.exp_ir = eir; v.exp_st = est;
        tbl.push_back(v);
    endtask

    initial begin
        logic [167:0] img_a, img_p, rst_img, out;
        logic [127:0] mem_a, mem_p;
        int           cyc;
        bit           halted;

        rst_n = 1'b0; scan_en_n = 1'b1; proc_en_n = 1'b1; scan_in = 1'b0;

        add_vec("bz_taken",   8'h95, 8'h00, KEY_OK,  3'b001, 2, 5'd5,  8'h00, 8'h95, 3'b001);
        add_vec("bz_not",     8'h95, 8'h01, KEY_OK,  3'b001, 2, 5'd1,  8'h01, 8'h95, 3'b001);
        add_vec("bnz_taken",  8'hA7, 8'h01, KEY_OK,  3'b001, 2, 5'd7,  8'h01, 8'hA7, 3'b001);
        add_vec("bnz_not",    8'hA7, 8'h00, KEY_OK,  3'b001, 2, 5'd1,  8'h00, 8'hA7, 3'b001);
        add_vec("jmp",        8'h8A, 8'h33, KEY_OK,  3'b001, 2, 5'd10, 8'h33, 8'h8A, 3'b001);
        add_vec("add",        8'h10, 8'h05, KEY_OK,  3'b001, 2, 5'd1,  8'h15, 8'h10, 3'b001);
        add_vec("add_locked", 8'h10, 8'h05, KEY_BAD, 3'b001, 2, 5'd1,  8'h16, 8'h10, 3'b001);
        add_vec("sub_locked", 8'h30, 8'h35, KEY_BAD, 3'b001, 2, 5'd1,  8'h05, 8'h30, 3'b001);
        add_vec("and",        8'h40, 8'hFF, KEY_OK,  3'b001, 2, 5'd1,  8'h40, 8'h40, 3'b001);
        add_vec("or",         8'h50, 8'h0F, KEY_OK,  3'b001, 2, 5'd1,  8'h5F, 8'h50, 3'b001);
        add_vec("xor",        8'h60, 8'h66, KEY_OK,  3'b001, 2, 5'd1,  8'h06, 8'h60, 3'b001);
        add_vec("lui",        8'hBA, 8'h12, KEY_OK,  3'b001, 2, 5'd1,  8'hA0, 8'hBA, 3'b001);
        add_vec("subi_wrap",  8'hD3, 8'h02, KEY_OK,  3'b001, 2, 5'd1,  8'hFF, 8'hD3, 3'b001);
        add_vec("addi_lock",  8'hEF, 8'hF5, KEY_BAD, 3'b001, 2, 5'd1,  8'h05, 8'hEF, 3'b001);
        add_vec("inc_locked", 8'hF1, 8'h01, KEY_BAD, 3'b001, 2, 5'd1,  8'h03, 8'hF1, 3'b001);
        add_vec("inc_wrap",   8'hF1, 8'hFF, KEY_OK,  3'b001, 2, 5'd1,  8'h00, 8'hF1, 3'b001);
        add_vec("dec_wrap",   8'hF3, 8'h00, KEY_OK,  3'b001, 2, 5'd1,  8'hFF, 8'hF3, 3'b001);
        add_vec("not",        8'hF4, 8'h81, KEY_OK,  3'b001, 2, 5'd1,  8'h7E, 8'hF4, 3'b001);
        add_vec("shl",        8'hF5, 8'h81, KEY_OK,  3'b001, 2, 5'd1,  8'h02, 8'hF5, 3'b001);
        add_vec("shr",        8'hF6, 8'h81, KEY_OK,  3'b001, 2, 5'd1,  8'h40, 8'hF6, 3'b001);
        add_vec("rol",        8'hF7, 8'h81, KEY_OK,  3'b001, 2, 5'd1,  8'h03, 8'hF7, 3'b001);
        add_vec("neg",        8'hF8, 8'h01, KEY_OK,  3'b001, 2, 5'd1,  8'hFF, 8'hF8, 3'b001);
        add_vec("ror",        8'hF9, 8'h81, KEY_OK,  3'b001, 2, 5'd1,  8'hC0, 8'hF9, 3'b001);
        add_vec("clr",        8'hF2, 8'h55, KEY_OK,  3'b001, 2, 5'd1,  8'h00, 8'hF2, 3'b001);
        add_vec("nop7",       8'h70, 8'h55, KEY_OK,  3'b001, 2, 5'd1,  8'h55, 8'h70, 3'b001);
        add_vec("nop_fa",     8'hFA, 8'h55, KEY_OK,  3'b001, 2, 5'd1,  8'h55, 8'hFA, 3'b001);
        add_vec("lda",        8'h00, 8'h55, KEY_OK,  3'b001, 2, 5'd1,  8'h00, 8'h00, 3'b001);
        add_vec("hlt",        8'hFF, 8'h55, KEY_OK,  3'b001, 2, 5'd1,  8'h55, 8'hFF, 3'b100);
        add_vec("bad_state",  8'h95, 8'h55, KEY_OK,  3'b011, 1, 5'd0,  8'h55, 8'h00, 3'b001);
        add_vec("halt_hold",  8'h95, 8'h55, KEY_OK,  3'b100, 4, 5'd0,  8'h55, 8'h00, 3'b100);

        rst_img = mk(16'h0, 128'h0, 8'h00, 8'h00, 5'd0, 3'b001);
        mem_a   = {8'hF0, 80'h0, 40'hE4E3E2E1E0};
        img_a   = mk(KEY_OK, mem_a, 8'h01, 8'hE0, 5'd1, 3'b001);
        mem_p   = {8'h10, 24'h0, 96'hFFF32EE1EFF8EFF52FFCF20F};
        img_p   = mk(KEY_OK, mem_p, 8'h00, 8'h00, 5'd0, 3'b001);

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_io", {24'h0, io_out}, 32'h00);
        readout(out);
        check_img("reset_image", out, rst_img);

        // ADDI sequence, unlocked
        load(img_a);
        #1;
        check("leds_after_load", {25'h0, io_out[6:0]}, {25'h0, mem_a[127:120] & 8'h7F});
        check("halt_flag_low", {31'h0, io_out[7]}, 32'h0);
        run(8);
        readout(out);
        check("seqA.acc", {24'h0, out[23:16]}, 32'h0B);
        check("seqA.pc", {27'h0, out[7:3]}, 32'd5);
        check("seqA.ir", {24'h0, out[15:8]}, 32'hE4);
        check("seqA.state", {29'h0, out[2:0]}, 32'd1);
        check_img("seqA.mem", {40'h0, out[151:24]}, {40'h0, mem_a});

        // Same sequence with a wrong key
        load(mk(KEY_OK ^ 16'h0001, mem_a, 8'h01, 8'hE0, 5'd1, 3'b001));
        run(8);
        readout(out);
        check("seqA_locked.acc", {24'h0, out[23:16]}, 32'h0F);
        check("seqA_locked.pc", {27'h0, out[7:3]}, 32'd5);

        // Scan mid-instruction, then resume from the captured image
        load(img_a);
        run(1);
        readout(out);
        check("mid.state", {29'h0, out[2:0]}, 32'b010);
        check("mid.ir", {24'h0, out[15:8]}, 32'hE1);
        check("mid.pc", {27'h0, out[7:3]}, 32'd2);
        load(out);
        run(1);
        readout(out);
        check("resume.acc", {24'h0, out[23:16]}, 32'h02);
        check("resume.state", {29'h0, out[2:0]}, 32'b001);

        // Idle hold
        load(img_a);
        repeat (10) @(negedge clk);
        readout(out);
        check_img("idle_hold", out, img_a);

        // Reset while running
        load(img_a);
        run(3);
        @(negedge clk);
        rst_n = 1'b0; proc_en_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; proc_en_n = 1'b1;
        readout(out);
        check_img("reset_midrun", out, rst_img);

        // Program to HLT
        load(img_p);
        @(negedge clk);
        proc_en_n = 1'b0;
        halted = 1'b0;
        cyc = 0;
        while (!halted && cyc < 256) begin
            @(negedge clk);
            cyc++;
            #1;
            halted = io_out[7];
        end
        check("prog.halt_seen", {31'h0, halted}, 32'h1);
        check("prog.halt_cycles", cyc, 32'd24);
        check("prog.leds", {25'h0, io_out[6:0]}, 32'h0);
        repeat (5) @(negedge clk);
        proc_en_n = 1'b1;
        readout(out);
        check("prog.m15", {24'h0, out[151:144]}, 32'h00);
        check("prog.m14", {24'h0, out[143:136]}, 32'h01);
        check("prog.state", {29'h0, out[2:0]}, 32'b100);
        check("prog.pc", {27'h0, out[7:3]}, 32'd12);
        check("prog.acc", {24'h0, out[23:16]}, 32'h00);

        // Single-instruction vectors
        foreach (tbl[k]) begin
            load(mk(tbl[k].key, {120'h0, tbl[k].instr}, tbl[k].acc, 8'h00, 5'd0, tbl[k].st));
            run(tbl[k].ncyc);
            readout(out);
            check($sformatf("%s.pc", tbl[k].name), {27'h0, out[7:3]}, {27'h0, tbl[k].exp_pc});
            check($sformatf("%s.acc", tbl[k].name), {24'h0, out[23:16]}, {24'h0, tbl[k].exp_acc});
            check($sformatf("%s.ir", tbl[k].name), {24'h0, out[15:8]}, {24'h0, tbl[k].exp_ir});
            check($sformatf("%s.state", tbl[k].name), {29'h0, out[2:0]}, {29'h0, tbl[k].exp_st});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
